fetch_unit: RTL and testbench

//   Instruction-fetch front end for the WISC-SP13 unpipelined core. Owns the PC,

---
 rtl/fetch_unit.sv | 120 ++++++++++++
 tb/tb_fetch_unit.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, fetches over imem req/ack and buffers one instruction.
// Optional misaligned-redirect trap enabled by defining FETCH_ALIGN_CHECK_EN.
module fetch_unit #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0800
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    output logic [15:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic        halt,
    output logic [15:0] pc,
    output logic [15:0] pc_plus2,
    output logic        halted,
    output logic        align_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_VALID,
        S_HALTED
    } state_t;

    state_t      state_q;
    logic [15:0] pc_q;
    logic [15:0] instr_q;
    logic        req_q;
    logic        valid_q;
    logic        halted_q;
    logic        align_err_q;

    logic [15:0] target_d;
    logic        misaligned_d;

    always_comb begin
        target_d     = redirect_pc;
        misaligned_d = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        misaligned_d = redirect_pc[0];
`else
        target_d[0]  = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            instr_q     <= NOP_INSTR;
            req_q       <= 1'b0;
            valid_q     <= 1'b0;
            halted_q    <= 1'b0;
            align_err_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_q <= S_REQ;
                    req_q   <= 1'b1;
                end
                S_REQ: begin
                    if (imem_ack) begin
                        instr_q <= imem_rdata;
                        req_q   <= 1'b0;
                        valid_q <= 1'b1;
                        state_q <= S_VALID;
                    end
                end
                S_VALID: begin
                    if (instr_ready) begin
                        valid_q <= 1'b0;
                        instr_q <= NOP_INSTR;
                        // halt outranks redirect; a misaligned target traps without touching pc
                        if (halt) begin
                            halted_q <= 1'b1;
                            state_q  <= S_HALTED;
                        end else if (redirect && misaligned_d) begin
                            halted_q    <= 1'b1;
                            align_err_q <= 1'b1;
                            state_q     <= S_HALTED;
                        end else if (redirect) begin
                            pc_q    <= target_d;
                            req_q   <= 1'b1;
                            state_q <= S_REQ;
                        end else begin
                            pc_q    <= pc_q + 16'd2;
                            req_q   <= 1'b1;
                            state_q <= S_REQ;
                        end
                    end
                end
                S_HALTED: begin
                    state_q <= S_HALTED;
                end
                default: begin
                    state_q <= S_IDLE;
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign pc          = pc_q;
    assign pc_plus2    = pc_q + 16'd2;
    assign halted      = halted_q;
    assign align_err   = align_err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit: a program-flow model predicts fetch addresses and
// instructions; a negedge monitor checks handshake timing, backpressure, halt and reset behaviour.
module tb_fetch_unit;

    localparam logic [15:0] RST_PC = 16'h0000;
    localparam logic [15:0] NOP    = 16'h0800;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        halt;
    logic [15:0] pc;
    logic [15:0] pc_plus2;
    logic        halted;
    logic        align_err;

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC (RST_PC),
        .NOP_INSTR(NOP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .instr      (instr),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .halt       (halt),
        .pc         (pc),
        .pc_plus2   (pc_plus2),
        .halted     (halted),
        .align_err  (align_err)
    );

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_addr_q[$];
    logic [15:0] exp_instr_q[$];
    logic [15:0] model_pc;
    bit          model_halted;
    bit          model_align;
    int          halt_cyc;
    int          consumes;

    // Memory image: byte swap plus xor, injective so any wrong address shows up as wrong data.
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_fetch(input logic [15:0] a);
        exp_addr_q.push_back(a);
        exp_instr_q.push_back(mem_word(a));
    endtask

    task automatic model_reset();
        model_pc     = RST_PC;
        model_halted = 1'b0;
        model_align  = 1'b0;
        halt_cyc     = 0;
        exp_addr_q.delete();
        exp_instr_q.delete();
        expect_fetch(RST_PC);
    endtask

    task automatic model_consume(input bit h, input bit r, input logic [15:0] tgt);
        if (h) begin
            model_halted = 1'b1;
            halt_cyc     = 0;
        end else if (r) begin
`ifdef FETCH_ALIGN_CHECK_EN
            if (tgt[0]) begin
                model_halted = 1'b1;
                model_align  = 1'b1;
                halt_cyc     = 0;
            end else begin
                model_pc = tgt;
                expect_fetch(model_pc);
            end
`else
            model_pc = {tgt[15:1], 1'b0};
            expect_fetch(model_pc);
`endif
        end else begin
            model_pc = model_pc + 16'd2;
            expect_fetch(model_pc);
        end
    endtask

    function automatic logic [15:0] pick_target();
        case ($urandom_range(0, 4))
            0:       return 16'hFFFC;
            1:       return 16'hFFFE;
            2:       return 16'h0041;
            3:       return 16'h0040;
            default: return 16'($urandom);
        endcase
    endfunction

    // Stimulus: memory responder, consumer and reference model, all updated 1 time unit after posedge.
    initial begin
        int  rst_hold;
        int  wait_cnt;
        bit  in_req;
        rst = 1'b0;
        imem_ack = 1'b0; imem_rdata = '0;
        instr_ready = 1'b0; redirect = 1'b0; redirect_pc = '0; halt = 1'b0;
        consumes = 0; rst_hold = 0; wait_cnt = 0; in_req = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(posedge clk);
            #1;
            if (model_halted) halt_cyc++;
            if (rst_hold > 0) begin
                rst_hold--;
                if (rst_hold == 0) rst = 1'b1;
                imem_ack = 1'($urandom_range(0, 1));
                imem_rdata = 16'($urandom);
                continue;
            end
            if ((model_halted && halt_cyc > 6 && $urandom_range(0, 3) == 0) ||
                $urandom_range(0, 199) == 0) begin
                rst = 1'b0;
                rst_hold = $urandom_range(1, 2);
                model_reset();
                instr_ready = 1'b0; redirect = 1'b0; halt = 1'b0;
                imem_ack = 1'b0; in_req = 1'b0;
                continue;
            end
            if (imem_req) begin
                if (!in_req) begin
                    in_req = 1'b1;
                    wait_cnt = $urandom_range(0, 3);
                end
                if (wait_cnt == 0) begin
                    imem_ack = 1'b1;
                    imem_rdata = mem_word(imem_addr);
                    in_req = 1'b0;
                end else begin
                    wait_cnt--;
                    imem_ack = 1'b0;
                    imem_rdata = 16'($urandom);
                end
            end else begin
                in_req = 1'b0;
                imem_ack = ($urandom_range(0, 3) == 0);
                imem_rdata = 16'($urandom);
            end
            halt = ($urandom_range(0, 19) == 0);
            redirect = ($urandom_range(0, 3) == 0);
            redirect_pc = pick_target();
            if (instr_valid) begin
                instr_ready = ($urandom_range(0, 9) < 6);
                if (instr_ready) begin
                    consumes++;
                    model_consume(halt, redirect, redirect_pc);
                end
            end else begin
                instr_ready = 1'($urandom_range(0, 1));
            end
        end
        chk("progress_consumes", 32'(consumes >= 100), 32'd1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    logic        p_req, p_ack, p_valid, p_ready;
    logic [15:0] p_addr;
    logic [15:0] held_instr;
    logic [15:0] a_exp;
    int          rel_cnt;
    int          stall;
    bit          first_pend;
    bit          exp_h;

    always @(negedge clk) begin
        if (!rst) begin
            chk("rst_req", imem_req, 0);
            chk("rst_valid", instr_valid, 0);
            chk("rst_instr", instr, NOP);
            chk("rst_pc", pc, RST_PC);
            chk("rst_halted", halted, 0);
            chk("rst_align_err", align_err, 0);
            p_req = 1'b0; p_ack = 1'b0; p_valid = 1'b0; p_ready = 1'b0; p_addr = '0;
            rel_cnt = 0; first_pend = 1'b1; stall = 0;
        end else begin
            rel_cnt++;
            exp_h = model_halted && halt_cyc >= 1;
            chk("halted", halted, 32'(exp_h));
            chk("align_err", align_err, 32'(model_align && halt_cyc >= 1));
            if (exp_h) begin
                chk("halt_req", imem_req, 0);
                chk("halt_valid", instr_valid, 0);
                chk("halt_instr", instr, NOP);
                chk("halt_pc", pc, model_pc);
                stall = 0;
            end else begin
                if (imem_req && !p_req) begin
                    if (first_pend) begin
                        chk("first_req_cycle", rel_cnt, 2);
                        first_pend = 1'b0;
                    end
                    if (exp_addr_q.size() == 0) begin
                        chk("unexpected_req_addr", imem_addr, 32'hFFFF_FFFF);
                    end else begin
                        a_exp = exp_addr_q.pop_front();
                        chk("fetch_addr", imem_addr, a_exp);
                        chk("pc", pc, a_exp);
                        chk("pc_plus2", pc_plus2, 16'(a_exp + 16'd2));
                    end
                end
                if (p_req && p_ack) chk("ack_to_valid", instr_valid, 1);
                if (p_req && !p_ack) begin
                    chk("req_hold", imem_req, 1);
                    chk("addr_hold", imem_addr, p_addr);
                end
                if (instr_valid && !p_valid) begin
                    if (exp_instr_q.size() == 0) begin
                        chk("unexpected_instr", instr, 32'hFFFF_FFFF);
                    end else begin
                        held_instr = exp_instr_q.pop_front();
                        chk("instr", instr, held_instr);
                    end
                end
                if (p_valid && !p_ready) begin
                    chk("bp_valid", instr_valid, 1);
                    chk("bp_instr", instr, held_instr);
                    chk("bp_noreq", imem_req, 0);
                end
                if (p_valid && p_ready) chk("consume_drop", instr_valid, 0);
                if (!instr_valid) chk("nop_when_invalid", instr, NOP);
                if (instr_valid) stall = 0;
                else stall++;
                if (stall > 10) begin
                    chk("stall_cycles", stall, 10);
                    stall = 0;
                end
            end
            p_req = imem_req; p_ack = imem_ack; p_valid = instr_valid;
            p_ready = instr_ready; p_addr = imem_addr;
        end
    end

endmodule
